// File: rtl/instr_dispatcher.sv
// instr_dispatcher: pops instructions from a show-ahead FIFO, decodes opcodes and
// issues each to the weight, matmul or activation unit over valid/ready handshakes.
module instr_dispatcher #(
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [79:0]            instr_in,
    input  logic                   fifo_empty,
    output logic                   next_en,
    input  logic                   start,
    output logic                   weight_valid,
    input  logic                   weight_ready,
    output logic                   matmul_valid,
    input  logic                   matmul_ready,
    output logic                   act_valid,
    input  logic                   act_ready,
    output logic [79:0]            instr_out,
    input  logic                   weight_busy,
    input  logic                   matmul_busy,
    input  logic                   act_busy,
    output logic                   halted,
    output logic                   illegal_op,
    output logic [COUNT_WIDTH-1:0] issue_count
);
    typedef enum logic [1:0] {S_HALT, S_RUN, S_ISSUE, S_SYNC} state_t;

    state_t                 state_q, state_d;
    logic [79:0]            instr_q, instr_d;
    logic                   illegal_q, illegal_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;

    logic [7:0] op_in, op_q;
    logic       in_unit, in_sync, in_halt, in_nop, pop, accept, idle;

    assign op_in   = instr_in[7:0];
    assign op_q    = instr_q[7:0];
    assign in_unit = op_in == 8'h08 || op_in[7:4] == 4'h2 || op_in[7:4] == 4'h8;
    assign in_nop  = op_in == 8'h00;
    assign in_sync = op_in == 8'h01;
    assign in_halt = op_in == 8'hFF;
    assign pop     = state_q == S_RUN && !fifo_empty;
    assign accept  = (weight_valid && weight_ready) || (matmul_valid && matmul_ready) ||
                     (act_valid && act_ready);
    assign idle    = !weight_busy && !matmul_busy && !act_busy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_HALT;
            instr_q   <= '0;
            illegal_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            illegal_q <= illegal_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        instr_d   = pop ? instr_in : instr_q;
        count_d   = count_q + COUNT_WIDTH'(accept);
        illegal_d = (state_q == S_HALT && start) ? 1'b0 :
                    (pop && !in_unit && !in_nop && !in_sync && !in_halt) ? 1'b1 : illegal_q;
        case (state_q)
            S_HALT:  state_d = start ? S_RUN : S_HALT;
            S_RUN:   state_d = !pop ? S_RUN : in_unit ? S_ISSUE : in_sync ? S_SYNC :
                               in_halt ? S_HALT : S_RUN;
            S_ISSUE: state_d = accept ? S_RUN : S_ISSUE;
            S_SYNC:  state_d = idle ? S_RUN : S_SYNC;
        endcase
    end

    // Unit select comes from the registered opcode so valid stays stable until accepted.
    always_comb begin
        next_en      = pop;
        halted       = state_q == S_HALT;
        weight_valid = state_q == S_ISSUE && op_q == 8'h08;
        matmul_valid = state_q == S_ISSUE && op_q[7:4] == 4'h2;
        act_valid    = state_q == S_ISSUE && op_q[7:4] == 4'h8;
        instr_out    = instr_q;
        illegal_op   = illegal_q;
        issue_count  = count_q;
    end
endmodule

// File: tb/tb_instr_dispatcher.sv
// tb_instr_dispatcher: directed checks of instr_dispatcher against a small FIFO model.
module tb_instr_dispatcher;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [79:0] instr_in;
    logic        fifo_empty, next_en, start = 1'b0;
    logic        weight_valid, matmul_valid, act_valid;
    logic        weight_ready = 1'b1, matmul_ready = 1'b1, act_ready = 1'b1;
    logic        weight_busy = 1'b0, matmul_busy = 1'b0, act_busy = 1'b0;
    logic [79:0] instr_out;
    logic        halted, illegal_op;
    logic [31:0] issue_count;

    logic [79:0] mem [16];
    logic [4:0]  rd = '0, wr = '0;
    int          checks = 0, failures = 0, bad_pops = 0;

    always #5 clk = ~clk;

    assign fifo_empty = rd == wr;
    assign instr_in   = mem[rd[3:0]];

    always @(posedge clk) begin
        if (next_en) rd <= rd + 5'd1;
        if (next_en && fifo_empty) bad_pops <= bad_pops + 1;
    end

    instr_dispatcher dut (
        .clk(clk), .rst(rst), .instr_in(instr_in), .fifo_empty(fifo_empty), .next_en(next_en),
        .start(start), .weight_valid(weight_valid), .weight_ready(weight_ready),
        .matmul_valid(matmul_valid), .matmul_ready(matmul_ready), .act_valid(act_valid),
        .act_ready(act_ready), .instr_out(instr_out), .weight_busy(weight_busy),
        .matmul_busy(matmul_busy), .act_busy(act_busy), .halted(halted),
        .illegal_op(illegal_op), .issue_count(issue_count)
    );

    function automatic logic [79:0] mk(input logic [7:0] op);
        logic [71:0] pay;
        pay = 72'hC0_FFEE_1234_5678_9ABC;
        return {pay ^ {64'd0, op}, op};
    endfunction

    task automatic push(input logic [7:0] op);
        mem[wr[3:0]] = mk(op);
        wr = wr + 5'd1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] vld();
        return {weight_valid, matmul_valid, act_valid};
    endfunction

    initial begin
        logic [2:0]  exp_v [7];
        logic        exp_n [7];
        logic [79:0] held;
        exp_v = '{3'b000, 3'b100, 3'b000, 3'b010, 3'b000, 3'b001, 3'b000};
        exp_n = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        #2;
        chk("rst_halted", 80'(halted), 80'd1);
        chk("rst_valids", 80'(vld()), 80'd0);
        chk("rst_next_en", 80'(next_en), 80'd0);
        chk("rst_instr_out", instr_out, 80'd0);
        chk("rst_illegal", 80'(illegal_op), 80'd0);
        chk("rst_count", 80'(issue_count), 80'd0);
        step();
        rst = 1'b1;
        push(8'h08); push(8'h21); push(8'h80);
        step(); step();
        chk("halt_no_pop", 80'(next_en), 80'd0);
        chk("halt_halted", 80'(halted), 80'd1);

        start = 1'b1;
        step();
        start = 1'b0;
        for (int t = 0; t < 7; t++) begin
            chk($sformatf("seq_valid_t%0d", t + 1), 80'(vld()), 80'(exp_v[t]));
            chk($sformatf("seq_next_en_t%0d", t + 1), 80'(next_en), 80'(exp_n[t]));
            if (t == 1) chk("seq_instr0", instr_out, mk(8'h08));
            if (t == 5) chk("seq_instr2", instr_out, mk(8'h80));
            step();
        end
        chk("seq_count", 80'(issue_count), 80'd3);

        matmul_ready = 1'b0;
        push(8'h20); push(8'h85);
        step();
        for (int t = 0; t < 10; t++) begin
            chk($sformatf("hold_mv_%0d", t), 80'(matmul_valid), 80'd1);
            chk($sformatf("hold_nen_%0d", t), 80'(next_en), 80'd0);
            chk($sformatf("hold_instr_%0d", t), instr_out, mk(8'h20));
            if (t < 9) step();
        end
        chk("hold_count_before", 80'(issue_count), 80'd3);
        matmul_ready = 1'b1;
        act_ready = 1'b0;
        step();
        chk("hold_count_after", 80'(issue_count), 80'd4);
        chk("hold_back_run", 80'(next_en), 80'd1);
        chk("hold_mv_drop", 80'(matmul_valid), 80'd0);
        step();
        chk("hold_act_issue", 80'(vld()), 80'(3'b001));
        act_ready = 1'b1;
        chk("act_ready_off_ignored", 80'(act_valid), 80'd1);
        step();
        chk("act_count", 80'(issue_count), 80'd5);

        matmul_busy = 1'b1;
        push(8'h01); push(8'h08);
        step();
        for (int t = 0; t < 5; t++) begin
            chk($sformatf("sync_wv_%0d", t), 80'(weight_valid), 80'd0);
            chk($sformatf("sync_nen_%0d", t), 80'(next_en), 80'd0);
            if (t == 4) matmul_busy = 1'b0;
            step();
        end
        chk("sync_pop", 80'(next_en), 80'd1);
        chk("sync_wv_early", 80'(weight_valid), 80'd0);
        step();
        chk("sync_wv", 80'(weight_valid), 80'd1);
        step();
        chk("sync_count", 80'(issue_count), 80'd6);

        push(8'h37); push(8'h08);
        step();
        chk("ill_set", 80'(illegal_op), 80'd1);
        chk("ill_discard", 80'(vld()), 80'd0);
        chk("ill_next_pop", 80'(next_en), 80'd1);
        step();
        chk("ill_wv", 80'(weight_valid), 80'd1);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("ill_sticky", 80'(illegal_op), 80'd1);
        chk("ill_not_halted", 80'(halted), 80'd0);
        chk("ill_count", 80'(issue_count), 80'd7);

        push(8'hFF); push(8'h08);
        step();
        for (int t = 0; t < 3; t++) begin
            chk($sformatf("hlt_halted_%0d", t), 80'(halted), 80'd1);
            chk($sformatf("hlt_nen_%0d", t), 80'(next_en), 80'd0);
            chk($sformatf("hlt_fifo_%0d", t), 80'(fifo_empty), 80'd0);
            step();
        end
        chk("hlt_illegal_kept", 80'(illegal_op), 80'd1);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("hlt_illegal_clr", 80'(illegal_op), 80'd0);
        chk("hlt_resume_pop", 80'(next_en), 80'd1);
        step();
        chk("hlt_wv", 80'(weight_valid), 80'd1);
        chk("hlt_instr", instr_out, mk(8'h08));
        step();
        chk("hlt_count", 80'(issue_count), 80'd8);

        weight_ready = 1'b0;
        push(8'h08);
        step();
        chk("rmid_wv", 80'(weight_valid), 80'd1);
        #2 rst = 1'b0;
        #1;
        chk("rmid_valids", 80'(vld()), 80'd0);
        chk("rmid_halted", 80'(halted), 80'd1);
        chk("rmid_count", 80'(issue_count), 80'd0);
        chk("rmid_instr", instr_out, 80'd0);
        step();
        rst = 1'b1;
        weight_ready = 1'b1;
        push(8'h08);
        for (int t = 0; t < 3; t++) begin
            step();
            chk($sformatf("rpost_halted_%0d", t), 80'(halted), 80'd1);
            chk($sformatf("rpost_nen_%0d", t), 80'(next_en), 80'd0);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        chk("rpost_pop", 80'(next_en), 80'd1);
        step();
        chk("rpost_wv", 80'(weight_valid), 80'd1);
        step();
        chk("rpost_count", 80'(issue_count), 80'd1);
        chk("no_pop_when_empty", 80'(bad_pops), 80'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
